// File: rtl/mc_pkg.sv
// Shared types for the multicycle LEGv8 core: FSM encodings, control word,
// opcode decoder, immediate generator and ALU.
package mc_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [63:0] PC_INC = 64'd4;
    localparam logic [4:0]  XZR    = 5'd31;
    localparam int          OPC_HI = 31;
    localparam int          OPC_LO = 21;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_ORR   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111
    } aluop_t;

    typedef enum logic [1:0] {IMM_I, IMM_D, IMM_B, IMM_CB} immsel_t;

    typedef struct packed {
        logic    reg2loc;
        logic    alusrc;
        logic    mem2reg;
        logic    regwrite;
        logic    memread;
        logic    memwrite;
        logic    branch;
        logic    uncond_branch;
        aluop_t  aluop;
        immsel_t immsel;
    } ctrl_t;

    // Pure opcode decoder; anything unrecognised leaves every control bit low.
    function automatic ctrl_t decode(input logic [10:0] op);
        ctrl_t c;
        c = '0;
        casez (op)
            11'b11111000010: begin c.alusrc = 1'b1; c.mem2reg = 1'b1; c.regwrite = 1'b1;
                                   c.memread = 1'b1; c.aluop = ALU_ADD; c.immsel = IMM_D; end
            11'b11111000000: begin c.reg2loc = 1'b1; c.alusrc = 1'b1; c.memwrite = 1'b1;
                                   c.aluop = ALU_ADD; c.immsel = IMM_D; end
            11'b10001011000: begin c.regwrite = 1'b1; c.aluop = ALU_ADD; end
            11'b11001011000: begin c.regwrite = 1'b1; c.aluop = ALU_SUB; end
            11'b10001010000: begin c.regwrite = 1'b1; c.aluop = ALU_AND; end
            11'b10101010000: begin c.regwrite = 1'b1; c.aluop = ALU_ORR; end
            11'b1001000100?: begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = ALU_ADD; c.immsel = IMM_I; end
            11'b1101000100?: begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = ALU_SUB; c.immsel = IMM_I; end
            11'b10110100???: begin c.reg2loc = 1'b1; c.branch = 1'b1; c.aluop = ALU_PASSB; c.immsel = IMM_CB; end
            11'b000101?????: begin c.uncond_branch = 1'b1; c.immsel = IMM_B; end
            default:         c = '0;
        endcase
        return c;
    endfunction

    // Branch offsets come out already scaled to bytes.
    function automatic logic [63:0] imm_gen(input logic [31:0] ir, input immsel_t sel);
        case (sel)
            IMM_I:   return {52'd0, ir[21:10]};
            IMM_D:   return {{55{ir[20]}}, ir[20:12]};
            IMM_B:   return {{36{ir[25]}}, ir[25:0], 2'b00};
            IMM_CB:  return {{43{ir[23]}}, ir[23:5], 2'b00};
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] alu(input logic [63:0] a, input logic [63:0] b, input aluop_t op);
        case (op)
            ALU_AND:   return a & b;
            ALU_ORR:   return a | b;
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_PASSB: return b;
            default:   return 64'd0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_proc_mc_control.sv
// Sequencer for the multicycle core: 3-5 states per instruction.
// FETCH and MEM hold until their memory ready arrives; requests drop at once on reset.
module mc_control
    import mc_pkg::*;
(
    input  logic   CLK,
    input  logic   resetl,
    input  logic   branch,
    input  logic   uncond_branch,
    input  logic   memread,
    input  logic   memwrite,
    input  logic   regwrite,
    input  logic   zero,
    input  logic   imem_ready,
    input  logic   dmem_ready,
    output state_t state,
    output logic   ir_we,
    output logic   ab_we,
    output logic   aluout_we,
    output logic   mdr_we,
    output logic   pc_we,
    output logic   pc_sel,
    output logic   rf_we,
    output logic   imem_req,
    output logic   dmem_req
);

    state_t nxt;
    logic   exec_done;
    logic   imem_q, dmem_q, wb_q;

    always_comb begin
        nxt       = state;
        exec_done = 1'b0;
        case (state)
            FETCH:  if (imem_ready) nxt = DECODE;
            DECODE: nxt = EXEC;
            EXEC: begin
                if (branch || uncond_branch) begin
                    nxt       = FETCH;
                    exec_done = 1'b1;
                end else if (memread || memwrite) begin
                    nxt = MEM;
                end else if (regwrite) begin
                    nxt = WB;
                end else begin
                    nxt       = FETCH;
                    exec_done = 1'b1;
                end
            end
            MEM:     if (dmem_ready) nxt = memwrite ? FETCH : WB;
            WB:      nxt = FETCH;
            default: nxt = FETCH;
        endcase
    end

    // Request/write strobes are registered alongside the state they belong to.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state  <= FETCH;
            imem_q <= 1'b1;
            dmem_q <= 1'b0;
            wb_q   <= 1'b0;
        end else begin
            state  <= nxt;
            imem_q <= (nxt == FETCH);
            dmem_q <= (nxt == MEM);
            wb_q   <= (nxt == WB);
        end
    end

    assign imem_req  = imem_q & resetl;
    assign dmem_req  = dmem_q & resetl;
    assign ir_we     = imem_req & imem_ready;
    assign ab_we     = (state == DECODE);
    assign aluout_we = (state == EXEC);
    assign mdr_we    = dmem_req & dmem_ready & memread;
    assign pc_sel    = (state == EXEC) & (uncond_branch | (branch & zero));
    assign pc_we     = exec_done | (dmem_req & dmem_ready & memwrite) | wb_q;
    assign rf_we     = wb_q;

endmodule

// File: rtl/multicycle_proc.sv
// LEGv8 multicycle core: shared ALU/register file, 3-5 cycles per instruction plus
// memory wait cycles; imem/dmem req is held with stable address until ready.
module multicycle_proc
    import mc_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic [63:0]       startpc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [63:0]       dmem_wdata,
    input  logic [63:0]       dmem_rdata,
    input  logic              dmem_ready,
    output logic [63:0]       currentpc,
    output logic [63:0]       dmemout,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  retired
);

    logic [31:0]      ir;
    logic [63:0]      a, b, aluout, mdr, pc;
    logic [CNT_W-1:0] retired_q;
    logic [63:0]      regs [0:31];

    ctrl_t       ctrl;
    state_t      st;
    logic [4:0]  rn, rm, rw;
    logic [63:0] imm64, alu_y, bus_w;
    logic        alu_zero, reg_wr;
    logic        ir_we, ab_we, aluout_we, mdr_we, pc_we, pc_sel, rf_we;

    assign ctrl     = decode(ir[OPC_HI:OPC_LO]);
    assign rn       = ir[9:5];
    assign rm       = ctrl.reg2loc ? ir[4:0] : ir[20:16];
    assign rw       = ir[4:0];
    assign imm64    = imm_gen(ir, ctrl.immsel);
    assign alu_y    = alu(a, ctrl.alusrc ? imm64 : b, ctrl.aluop);
    assign alu_zero = (alu_y == 64'd0);
    assign bus_w    = ctrl.mem2reg ? mdr : aluout;
    assign reg_wr   = rf_we & (rw != XZR);

    mc_control u_ctl (
        .CLK           (CLK),
        .resetl        (resetl),
        .branch        (ctrl.branch),
        .uncond_branch (ctrl.uncond_branch),
        .memread       (ctrl.memread),
        .memwrite      (ctrl.memwrite),
        .regwrite      (ctrl.regwrite),
        .zero          (alu_zero),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .state         (st),
        .ir_we         (ir_we),
        .ab_we         (ab_we),
        .aluout_we     (aluout_we),
        .mdr_we        (mdr_we),
        .pc_we         (pc_we),
        .pc_sel        (pc_sel),
        .rf_we         (rf_we),
        .imem_req      (imem_req),
        .dmem_req      (dmem_req)
    );

    always_ff @(posedge CLK) begin
        if (reg_wr) regs[rw] <= bus_w;
    end

    // X31 always reads as zero.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            ir        <= 32'd0;
            a         <= 64'd0;
            b         <= 64'd0;
            aluout    <= 64'd0;
            mdr       <= 64'd0;
            pc        <= startpc;
            retired_q <= '0;
        end else begin
            if (ir_we)     ir     <= imem_rdata;
            if (ab_we)     a      <= (rn == XZR) ? 64'd0 : regs[rn];
            if (ab_we)     b      <= (rm == XZR) ? 64'd0 : regs[rm];
            if (aluout_we) aluout <= alu_y;
            if (mdr_we)    mdr    <= dmem_rdata;
            if (pc_we) begin
                pc        <= pc_sel ? pc + imm64 : pc + PC_INC;
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign imem_addr  = pc[ADDR_W-1:0];
    assign dmem_addr  = aluout[ADDR_W-1:0];
    assign dmem_wdata = b;
    assign dmem_we    = dmem_req & ctrl.memwrite;
    assign currentpc  = pc;
    assign dmemout    = mdr;
    assign state      = st;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_proc.sv
// Directed bench for multicycle_proc with behavioural imem/dmem and controllable waits.
module tb_multicycle_proc;

    localparam int ADDR_W = 64;
    localparam int CNT_W  = 32;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;

    logic              CLK = 1'b0;
    logic              resetl;
    logic [63:0]       startpc;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ready;
    logic              dmem_req, dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [63:0]       dmem_wdata, dmem_rdata;
    logic              dmem_ready;
    logic [63:0]       currentpc, dmemout;
    logic [2:0]        state;
    logic [CNT_W-1:0]  retired;

    int tests = 0;
    int fails = 0;

    logic [31:0] imem_mem [0:255];
    logic [63:0] dmem_mem [0:63];
    int          wr_count = 0;

    int          cyc, wr_cyc, icyc, dcyc, wc0;
    logic        wr_seen, m_we, addr_stable, found;
    logic [4:0]  wr_rd;
    logic [63:0] wr_dat, m_addr, m_wdata;

    multicycle_proc #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .resetl     (resetl),
        .startpc    (startpc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .currentpc  (currentpc),
        .dmemout    (dmemout),
        .state      (state),
        .retired    (retired)
    );

    always #5 CLK = ~CLK;

    assign imem_rdata = imem_mem[imem_addr[9:2]];
    assign dmem_rdata = dmem_mem[dmem_addr[8:3]];

    always @(posedge CLK) begin
        if (dmem_req && dmem_ready && dmem_we) begin
            dmem_mem[dmem_addr[8:3]] <= dmem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    function automatic logic [31:0] enc_r(input logic [10:0] opc, input logic [4:0] rm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {opc, rm, 6'd0, rn, rd};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rn, input logic [4:0] rd);
        return {OP_ADDI, imm, rn, rd};
    endfunction

    function automatic logic [31:0] enc_d(input logic [10:0] opc, input logic [8:0] imm,
                                          input logic [4:0] rn, input logic [4:0] rt);
        return {opc, imm, 2'b00, rn, rt};
    endfunction

    function automatic logic [31:0] enc_cb(input logic [18:0] imm, input logic [4:0] rt);
        return {8'b10110100, imm, rt};
    endfunction

    function automatic logic [31:0] enc_b(input logic [25:0] imm);
        return {6'b000101, imm};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        imem_mem[addr[9:2]] = word;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one instruction to retirement, inserting the requested ready-low cycles.
    task automatic run(input int iwait, input int dwait);
        logic [CNT_W-1:0] r0;
        logic [63:0]      pc0;
        int               iw, dw;
        logic             done;
        r0 = retired; pc0 = currentpc; iw = iwait; dw = dwait; done = 1'b0;
        cyc = 0; icyc = 0; dcyc = 0; wr_seen = 1'b0; wr_cyc = 0; wr_rd = 5'd0; wr_dat = 64'd0;
        m_we = 1'b0; m_addr = 64'd0; m_wdata = 64'd0; addr_stable = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge CLK);
            cyc++;
            if (imem_req && iw > 0) begin imem_ready = 1'b0; iw--; end else imem_ready = 1'b1;
            if (dmem_req && dw > 0) begin dmem_ready = 1'b0; dw--; end else dmem_ready = 1'b1;
            if (imem_req) begin
                icyc++;
                if (imem_addr !== pc0) addr_stable = 1'b0;
            end
            if (dmem_req) begin
                if (dcyc > 0 && (dmem_addr !== m_addr || dmem_wdata !== m_wdata || dmem_we !== m_we))
                    addr_stable = 1'b0;
                m_addr = dmem_addr; m_wdata = dmem_wdata; m_we = dmem_we;
                dcyc++;
            end
            if (dut.reg_wr) begin
                wr_seen = 1'b1; wr_cyc = cyc; wr_rd = dut.rw; wr_dat = dut.bus_w;
            end
            @(posedge CLK);
            #1;
            done = (retired !== r0);
        end
        chk("retire_in_budget", 64'(done), 64'd1);
    endtask

    initial begin
        resetl = 1'b0; startpc = 64'h100; imem_ready = 1'b1; dmem_ready = 1'b1;
        for (int i = 0; i < 256; i++) imem_mem[i] = 32'd0;
        put(32'h100, enc_i(12'd5, 5'd31, 5'd1));
        put(32'h104, enc_i(12'd7, 5'd31, 5'd2));
        put(32'h108, enc_r(OP_ADD, 5'd2, 5'd1, 5'd3));
        put(32'h10C, enc_r(OP_ADD, 5'd2, 5'd1, 5'd31));
        put(32'h110, enc_i(12'h040, 5'd31, 5'd0));
        put(32'h114, enc_d(OP_STUR, 9'd8, 5'd0, 5'd3));
        put(32'h118, enc_d(OP_LDUR, 9'd8, 5'd0, 5'd4));
        put(32'h11C, enc_d(OP_LDUR, 9'd8, 5'd0, 5'd6));
        put(32'h120, enc_i(12'd0, 5'd31, 5'd5));
        put(32'h124, enc_b(26'd55));
        put(32'h200, enc_cb(19'd4, 5'd5));
        put(32'h210, enc_i(12'd1, 5'd31, 5'd5));
        put(32'h214, enc_cb(19'd4, 5'd5));
        put(32'h218, enc_b(26'd58));
        put(32'h300, enc_b(26'h3FFFFFE));
        put(32'h2FC, enc_d(OP_STUR, 9'd16, 5'd0, 5'd1));

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_pc", currentpc, 64'h100);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_dmem_req", 64'(dmem_req), 64'd0);
        chk("rst_retired", 64'(retired), 64'd0);
        chk("rst_mdr", dmemout, 64'd0);
        @(posedge CLK);
        #1 resetl = 1'b1;
        #1;
        chk("rel_imem_req", 64'(imem_req), 64'd1);
        chk("rel_imem_addr", imem_addr, 64'h100);

        run(0, 0);
        chk("addi_wr_rd", 64'(wr_rd), 64'd1);
        chk("addi_wr_dat", wr_dat, 64'd5);
        chk("addi_cyc", 64'(cyc), 64'd4);
        run(0, 0);
        run(0, 0);
        chk("add_cyc", 64'(cyc), 64'd4);
        chk("add_wr_cyc", 64'(wr_cyc), 64'd4);
        chk("add_wr_rd", 64'(wr_rd), 64'd3);
        chk("add_wr_dat", wr_dat, 64'd12);
        chk("add_pc", currentpc, 64'h10C);
        chk("add_retired", 64'(retired), 64'd3);
        run(0, 0);
        chk("xzr_no_write", 64'(wr_seen), 64'd0);
        chk("xzr_cyc", 64'(cyc), 64'd4);
        run(0, 0);

        run(0, 0);
        chk("st_addr", m_addr, 64'h48);
        chk("st_we", 64'(m_we), 64'd1);
        chk("st_wdata", m_wdata, 64'd12);
        chk("st_cyc", 64'(cyc), 64'd4);
        chk("st_no_rf_write", 64'(wr_seen), 64'd0);
        chk("st_mem_writes", 64'(wr_count), 64'd1);
        run(0, 0);
        chk("ld_cyc", 64'(cyc), 64'd5);
        chk("ld_we", 64'(m_we), 64'd0);
        chk("ld_wr_cyc", 64'(wr_cyc), 64'd5);
        chk("ld_wr_rd", 64'(wr_rd), 64'd4);
        chk("ld_wr_dat", wr_dat, 64'd12);
        chk("ld_mdr", dmemout, 64'd12);
        chk("ld_retired", 64'(retired), 64'd7);

        run(3, 2);
        chk("ldw_cyc", 64'(cyc), 64'd10);
        chk("ldw_imem_req_cycles", 64'(icyc), 64'd4);
        chk("ldw_dmem_req_cycles", 64'(dcyc), 64'd3);
        chk("ldw_addr_stable", 64'(addr_stable), 64'd1);
        chk("ldw_wr_rd", 64'(wr_rd), 64'd6);
        chk("ldw_wr_dat", wr_dat, 64'd12);

        run(0, 0);
        run(0, 0);
        chk("b_fwd_pc", currentpc, 64'h200);
        chk("b_fwd_cyc", 64'(cyc), 64'd3);
        run(0, 0);
        chk("cbz_taken_pc", currentpc, 64'h210);
        chk("cbz_taken_cyc", 64'(cyc), 64'd3);
        run(0, 0);
        run(0, 0);
        chk("cbz_not_taken_pc", currentpc, 64'h218);
        chk("cbz_not_taken_cyc", 64'(cyc), 64'd3);
        run(0, 0);
        chk("b_to_300_pc", currentpc, 64'h300);
        run(0, 0);
        chk("b_back_pc", currentpc, 64'h2F8);
        chk("b_back_cyc", 64'(cyc), 64'd3);
        run(0, 0);
        chk("nop_pc", currentpc, 64'h2FC);
        chk("nop_cyc", 64'(cyc), 64'd3);
        chk("nop_no_write", 64'(wr_seen), 64'd0);
        chk("nop_retired", 64'(retired), 64'd16);

        dmem_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge CLK);
            found = (state === 3'd3);
        end
        chk("ab_reach_mem", 64'(found), 64'd1);
        chk("ab_dmem_req", 64'(dmem_req), 64'd1);
        chk("ab_dmem_we", 64'(dmem_we), 64'd1);
        chk("ab_dmem_addr", dmem_addr, 64'h50);
        wc0 = wr_count;
        startpc = 64'h180;
        #2 resetl = 1'b0;
        #1;
        chk("ab_dmem_req_async", 64'(dmem_req), 64'd0);
        chk("ab_imem_req_async", 64'(imem_req), 64'd0);
        chk("ab_state", 64'(state), 64'd0);
        chk("ab_pc", currentpc, 64'h180);
        chk("ab_retired", 64'(retired), 64'd0);
        chk("ab_mdr", dmemout, 64'd0);
        dmem_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("ab_no_mem_write", 64'(wr_count), 64'(wc0));
        chk("ab_hold_pc", currentpc, 64'h180);
        resetl = 1'b1;
        #1;
        chk("ab_rel_imem_addr", imem_addr, 64'h180);
        chk("ab_rel_imem_req", 64'(imem_req), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_proc.md
Name: multicycle_proc

Overview:
- LEGv8 multicycle processor core, successor to the single-cycle core.
- Executes one instruction over 3-5 states, sharing the ALU and register file across the steps of each instruction.
- Talks to external instruction and data memories through req/ready handshakes, so memory latency can vary.
- Reuses the existing RegisterFile, alu, ImmGenerator and SingleCycleControl (used as a pure opcode decoder). Adds a retired-instruction counter.

Parameters:
- ADDR_W, 64: memory address width. imem_addr and dmem_addr carry the low ADDR_W bits of the 64-bit PC/ALU result.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- CLK in 1: clock; all state updates on posedge.
- resetl in 1: asynchronous, active-low reset.
- startpc in 64: PC value loaded while resetl is low.
- imem_req out 1: instruction fetch request.
- imem_addr out ADDR_W: fetch address.
- imem_rdata in 32: instruction word; valid when imem_ready=1.
- imem_ready in 1: fetch completes on a posedge where imem_req&imem_ready.
- dmem_req out 1: data access request.
- dmem_we out 1: 1=store, 0=load.
- dmem_addr out ADDR_W: data address (ALUOut).
- dmem_wdata out 64: store data (B register).
- dmem_rdata in 64: load data; valid when dmem_ready=1.
- dmem_ready in 1: access completes on a posedge where dmem_req&dmem_ready.
- currentpc out 64: PC of the instruction in progress.
- dmemout out 64: MDR, the last loaded data word.
- state out 3: current FSM state, for debug.
- retired out CNT_W: count of completed instructions.

Behaviour:
- Reset (async, resetl=0):
  - state=FETCH, currentpc=startpc.
  - IR, A, B, ALUOut, MDR, retired all 0.
  - Request outputs are gated by resetl, so imem_req=dmem_req=0 immediately.
  - Reset mid-access aborts the access; no register-file or memory write occurs.
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- FETCH:
  - imem_req=1, imem_addr=currentpc.
  - Stay in FETCH while imem_ready=0.
  - On ready: IR<=imem_rdata, go to DECODE.
- DECODE:
  - Decoder is driven from IR[31:21]; rm select follows reg2loc.
  - A<=reg[IR[9:5]], B<=reg[rm]. Imm64 is generated from IR, go to EXEC.
- EXEC: ALUOut<=alu(A, alusrc?Imm64:B), zero latched. Exit depends on decode:
  - uncond_branch, or branch with zero=1: pc<=pc+Imm64 (ImmGenerator output is already word-scaled). Retire, go to FETCH.
  - branch with zero=0: pc<=pc+4, retire, go to FETCH.
  - memread or memwrite: go to MEM.
  - regwrite: go to WB.
  - No control bit set (unknown opcode): treated as NOP. pc<=pc+4, retire, go to FETCH.
- MEM:
  - dmem_req=1, dmem_we=memwrite, dmem_addr=ALUOut, dmem_wdata=B.
  - Hold state, address and data stable until dmem_ready.
  - On ready, load: MDR<=dmem_rdata, go to WB.
  - On ready, store: pc<=pc+4, retire, go to FETCH.
- WB:
  - RegWr pulses for exactly this one cycle: BusW=mem2reg?MDR:ALUOut, RW=IR[4:0].
  - The write is suppressed when rd=31 (XZR).
  - pc<=pc+4, retire, go to FETCH.
- Request outputs are 0 in every state other than FETCH (imem) and MEM (dmem).
- Memory writes happen only on the MEM handshake. The register file is written only in WB.
- PC and adder arithmetic are modulo 2^64. retired wraps modulo 2^CNT_W.
- Latency with zero-wait memory (ready tied 1):
  - R-type/ALU-immediate: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - B, CBZ, NOP: 3 cycles.
  - Each wait cycle adds 1.

Decomposition:
- Shared package mc_pkg:
  - state encodings.
  - PC_INC=4.
  - XZR=31.
  - opcode field bounds [31:21].
- One natural sub-module: mc_control.
  - Contains the FSM only: state register, next-state logic, and the enables (ir_we, ab_we, aluout_we, mdr_we, pc_we, pc_sel, rf_we, imem_req, dmem_req).
  - Datapath registers and existing units stay in multicycle_proc.

Test Plan:
- Reset: hold resetl=0 with startpc=0x100, toggle CLK -> currentpc=0x100, state=0, imem_req=0, retired=0. Release reset -> imem_req=1, imem_addr=0x100.
- ADD X3,X1,X2 with X1=5, X2=7, zero-wait memory -> X3=12 written in cycle 4, currentpc=0x104, retired=1. ADD X31,X1,X2 -> no register-file write.
- STUR X3,[X0,#8] then LDUR X4,[X0,#8] with X0=0x40 -> dmem_addr=0x48, dmem_we=1, wdata=12 on the store. X4=12 and dmemout=12 after the load. Elapsed 4+5 cycles, retired=2.
- Wait states: imem_ready low 3 cycles on the fetch, then dmem_ready low 2 cycles on a load -> FSM holds with stable addresses; total load latency 5+3+2=10 cycles.
- Branches: CBZ X5,#+4 with X5=0 at pc 0x200 -> pc=0x210. CBZ with X5=1 -> pc=0x204. B #-2 at 0x300 -> pc=0x2F8; each takes 3 cycles.
- Reset asserted mid-MEM while dmem_ready=0 -> dmem_req drops with no clock edge, memory unchanged, currentpc=startpc, retired=0.
